// File: rtl/garage_input_conditioner_if.sv
// garage_input_conditioner_if
//   Bundles the raw switch inputs and the conditioned outputs of the garage
//   door input conditioner.
//   master : drives the raw inputs, observes the conditioned outputs
//   slave  : the conditioner itself
// Signals:
//   Btn_Raw, UP_Lim_Raw, DN_Lim_Raw : raw active-high inputs (asynchronous)
//   Activate                        : one-cycle pulse per accepted press
//   UP_Max, DN_Max                  : debounced limit levels
//   Fault                           : both debounced limits active
interface garage_input_conditioner_if;
  logic Btn_Raw;
  logic UP_Lim_Raw;
  logic DN_Lim_Raw;
  logic Activate;
  logic UP_Max;
  logic DN_Max;
  logic Fault;

  modport master (
    output Btn_Raw, UP_Lim_Raw, DN_Lim_Raw,
    input  Activate, UP_Max, DN_Max, Fault
  );

  modport slave (
    input  Btn_Raw, UP_Lim_Raw, DN_Lim_Raw,
    output Activate, UP_Max, DN_Max, Fault
  );
endinterface

// File: rtl/garage_input_conditioner.sv
// garage_input_conditioner
//   Synchronises and debounces the wall push-button and both limit switches
//   for the garage door controller. Produces one Activate pulse per debounced
//   press, clean UP_Max / DN_Max levels and a Fault flag when both limits are
//   active at once (Activate is suppressed while Fault is set).
// Ports:
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-high reset
//   io   : garage_input_conditioner_if.slave (raw inputs in, conditioned out)
// Parameters:
//   DEBOUNCE_CYCLES : consecutive disagreeing cycles needed to flip (>= 2)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//   LOCKOUT_CYCLES  : post-press lockout length (LOCKOUT_EN builds only)
// Build option:
//   LOCKOUT_EN : when defined, every Activate pulse starts a lockout during
//                which new presses are dropped. Undefined: no lockout logic.
module garage_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int LOCKOUT_CYCLES  = 50
) (
  input  logic                         CLK,
  input  logic                         RST,
  garage_input_conditioner_if.slave    io
);

  localparam int CH_BTN = 0;
  localparam int CH_UP  = 1;
  localparam int CH_DN  = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       raw;
  logic [2:0]       sync_a;
  logic [2:0]       sync_b;
  logic [2:0]       stb;
  logic [CNT_W-1:0] cnt [3];
  logic             btn_d;
  logic             fault;
  logic             activate;
  logic             rise;
  logic             lock_ok;
  logic             act_next;

  assign raw = {io.DN_Lim_Raw, io.UP_Lim_Raw, io.Btn_Raw};

  // Two-flop synchroniser, one per raw input.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Per-channel debounce: the count only advances while the synchronised
  // input disagrees with the debounced value; any agreeing cycle restarts it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stb <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == stb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stb[i] <= sync_b[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = stb[CH_BTN] & ~btn_d;

`ifdef LOCKOUT_EN
  localparam int LK_W = (LOCKOUT_CYCLES < 1) ? 1 : $clog2(LOCKOUT_CYCLES + 1);
  logic [LK_W-1:0] lock_cnt;

  // Loaded on the same edge that raises Activate, then counts down to zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_cnt <= '0;
    end else if (act_next) begin
      lock_cnt <= LK_W'(LOCKOUT_CYCLES);
    end else if (lock_cnt != '0) begin
      lock_cnt <= lock_cnt - 1'b1;
    end
  end

  assign lock_ok = (lock_cnt == '0);
`else
  assign lock_ok = 1'b1;
`endif

  // A rise seen while Fault (or lockout) is active is dropped, not held over.
  assign act_next = rise & ~fault & lock_ok;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_d    <= 1'b0;
      fault    <= 1'b0;
      activate <= 1'b0;
    end else begin
      btn_d    <= stb[CH_BTN];
      fault    <= stb[CH_UP] & stb[CH_DN];
      activate <= act_next;
    end
  end

  assign io.Activate = activate;
  assign io.UP_Max   = stb[CH_UP];
  assign io.DN_Max   = stb[CH_DN];
  assign io.Fault    = fault;

endmodule

// File: tb/tb_garage_input_conditioner.sv
module tb_garage_input_conditioner;
  localparam int DEB  = 4;
  localparam int LOCK = 20;

  localparam int S_UP = 0;
  localparam int S_DN = 1;
  localparam int S_FLT = 2;
  localparam int S_ACT = 3;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic btn = 1'b0;
  logic up  = 1'b0;
  logic dn  = 1'b0;

  garage_input_conditioner_if io ();

  assign io.Btn_Raw    = btn;
  assign io.UP_Lim_Raw = up;
  assign io.DN_Lim_Raw = dn;

  garage_input_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (5),
    .LOCKOUT_CYCLES  (LOCK)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .io  (io)
  );

  always #10 CLK = ~CLK;

  typedef struct {
    int at_edge;
    int sig;
    bit val;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  edge_n = 0;
  int  rst_cnt = 0;
  int  rst_used = 0;
  int  act_pulses = 0;

  // Every rising edge of RST is noted so the model also honours a reset
  // pulse that falls between two clock edges.
  initial forever begin
    @(posedge RST);
    rst_cnt++;
  end

  // Reference model. Raw samples are kept as a history word (bit 0 newest).
  // A debounced level flips when the DEB samples that have made it through
  // the synchroniser (history positions 2..DEB+1) all disagree with it.
  logic [DEB+1:0] h_b = '0, h_u = '0, h_d = '0;
  bit m_b, m_u, m_d, m_f, m_a, m_r;
  bit act_seen;
  int last_act;

  function automatic bit settle(input logic [DEB+1:0] h, input bit s);
    logic [DEB-1:0] win;
    win = h[DEB+1:2];
    if (s ? (win == '0) : (win == '1)) return ~s;
    return s;
  endfunction

  task automatic push_ev(input int s, input bit v);
    ev_t e;
    e.at_edge = edge_n;
    e.sig = s;
    e.val = v;
    exp_q.push_back(e);
  endtask

  initial begin
    bit n_b, n_u, n_d, n_f, n_a, ok;
    m_b = 0; m_u = 0; m_d = 0; m_f = 0; m_a = 0; m_r = 0;
    act_seen = 0; last_act = 0;
    forever begin
      @(posedge CLK);
      edge_n++;
      if (RST || rst_cnt != rst_used) begin
        rst_used = rst_cnt;
        if (m_u) push_ev(S_UP, 0);
        if (m_d) push_ev(S_DN, 0);
        if (m_f) push_ev(S_FLT, 0);
        if (m_a) push_ev(S_ACT, 0);
        h_b = '0; h_u = '0; h_d = '0;
        m_b = 0; m_u = 0; m_d = 0; m_f = 0; m_a = 0; m_r = 0;
        act_seen = 0;
      end
      if (!RST) begin
        h_b = {h_b[DEB:0], btn};
        h_u = {h_u[DEB:0], up};
        h_d = {h_d[DEB:0], dn};
        n_b = settle(h_b, m_b);
        n_u = settle(h_u, m_u);
        n_d = settle(h_d, m_d);
        n_f = m_u & m_d;
        ok = 1;
`ifdef LOCKOUT_EN
        if (act_seen && edge_n <= last_act + LOCK) ok = 0;
`endif
        n_a = m_r & ~m_f & ok;
        if (n_a) begin
          last_act = edge_n;
          act_seen = 1;
        end
        if (n_u != m_u) push_ev(S_UP, n_u);
        if (n_d != m_d) push_ev(S_DN, n_d);
        if (n_f != m_f) push_ev(S_FLT, n_f);
        if (n_a != m_a) push_ev(S_ACT, n_a);
        m_r = n_b & ~m_b;
        m_b = n_b; m_u = n_u; m_d = n_d; m_f = n_f; m_a = n_a;
      end
    end
  end

  // Monitor: every observed output change must match the next expected event.
  initial begin
    bit prev [4];
    bit cur [4];
    ev_t e;
    for (int i = 0; i < 4; i++) prev[i] = 0;
    forever begin
      @(negedge CLK);
      cur[S_UP]  = io.UP_Max;
      cur[S_DN]  = io.DN_Max;
      cur[S_FLT] = io.Fault;
      cur[S_ACT] = io.Activate;
      while (exp_q.size() > 0 && exp_q[0].at_edge < edge_n) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event: sig %0d never went to %0b at edge %0d (now edge %0d)",
                 e.sig, e.val, e.at_edge, edge_n);
      end
      if (cur[S_ACT] && !prev[S_ACT]) act_pulses++;
      for (int s = 0; s < 4; s++) begin
        if (cur[s] != prev[s]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: sig %0d went to %0b at edge %0d, none expected",
                     s, cur[s], edge_n);
          end else begin
            e = exp_q.pop_front();
            if (e.sig != s || e.at_edge != edge_n || e.val != cur[s]) begin
              errors++;
              $display("FAIL event: got sig %0d=%0b at edge %0d, required sig %0d=%0b at edge %0d",
                       s, cur[s], edge_n, e.sig, e.val, e.at_edge);
            end
          end
          prev[s] = cur[s];
        end
      end
    end
  end

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_activate"}, io.Activate, 1'b0);
    check({tag, "_up_max"},   io.UP_Max,   1'b0);
    check({tag, "_dn_max"},   io.DN_Max,   1'b0);
    check({tag, "_fault"},    io.Fault,    1'b0);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0;
    int req;
    #1 RST = 1'b1;
    wait_cyc(3);
    #2 RST = 1'b0;

    // Reset state and a short asynchronous reset pulse.
    wait_cyc(2);
    check_all_zero("reset");
    #3 RST = 1'b1;
    #1 check_all_zero("rst_pulse_idle");
    RST = 1'b0;
    wait_cyc(3);

    // Held press: one pulse, none on release.
    n0 = act_pulses;
    btn = 1; wait_cyc(30);
    btn = 0; wait_cyc(10);
    check_int("held_press_pulses", act_pulses - n0, 1);

    // Glitches of 1..3 cycles never get through.
    n0 = act_pulses;
    for (int g = 1; g <= 3; g++) begin
      btn = 1; wait_cyc(g);
      btn = 0; wait_cyc(3);
    end
    wait_cyc(6);
    check_int("glitch_pulses", act_pulses - n0, 0);

    // Limits, fault and press suppression.
    up = 1; wait_cyc(10);
    dn = 1; wait_cyc(10);
    check("fault_set", io.Fault, 1'b1);
    n0 = act_pulses;
    btn = 1; wait_cyc(10);
    btn = 0; wait_cyc(10);
    check_int("fault_press_pulses", act_pulses - n0, 0);
    up = 0; wait_cyc(10);
    check("fault_clear", io.Fault, 1'b0);
    check("dn_still_set", io.DN_Max, 1'b1);

    // Asynchronous reset mid-cycle drops a high output immediately.
    #3 RST = 1'b1;
    #1 check_all_zero("rst_pulse_active");
    RST = 1'b0;
    wait_cyc(10);

    // Reset in the middle of a DN debounce discards the count.
    dn = 0; wait_cyc(10);
    dn = 1; wait_cyc(3);
    #2 RST = 1'b1;
    @(negedge CLK);
    #2 RST = 1'b0;
    wait_cyc(12);
    dn = 0; wait_cyc(10);

    // Two presses 12 cycles apart, then two presses 25 cycles apart.
    n0 = act_pulses;
    btn = 1; wait_cyc(6);
    btn = 0; wait_cyc(6);
    btn = 1; wait_cyc(6);
    btn = 0; wait_cyc(30);
`ifdef LOCKOUT_EN
    req = 1;
`else
    req = 2;
`endif
    check_int("presses_12_apart", act_pulses - n0, req);
    n0 = act_pulses;
    btn = 1; wait_cyc(6);
    btn = 0; wait_cyc(19);
    btn = 1; wait_cyc(6);
    btn = 0; wait_cyc(30);
    check_int("presses_25_apart", act_pulses - n0, 2);

    // Randomised activity on all three inputs.
    repeat (80) begin
      btn = 1'($urandom_range(0, 1));
      up  = 1'($urandom_range(0, 1));
      dn  = 1'($urandom_range(0, 1));
      wait_cyc($urandom_range(1, 9));
    end
    btn = 0; up = 0; dn = 0;
    wait_cyc(30);
    check_all_zero("final");

    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL leftover_event: sig %0d to %0b at edge %0d never observed",
               e.sig, e.val, e.at_edge);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
